// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 receive-side decoder.
// Contents: decoder state enum, pixel width, bit-counter width and
// default pulse timing for a 50 MHz clock.
package ws2812_pkg;

    localparam int unsigned PIXEL_W   = 24;
    localparam int unsigned BIT_CNT_W = 5;

    // Default timing in clk cycles at 50 MHz
    localparam int unsigned T_MIN_DEF    = 5;     // 100 ns
    localparam int unsigned T_THRESH_DEF = 25;    // 500 ns
    localparam int unsigned T_MAX_DEF    = 50;    // 1 us
    localparam int unsigned RESET_DEF    = 2500;  // 50 us

    typedef enum logic [2:0] {
        WAIT_RST,
        IDLE,
        HIGH,
        LOW,
        FWD,
        ERR
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Ports: clk, rst_n (synchronous, active-low), d (async in), q (synchronized out).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ws2812_decoder.sv
// WS2812-style single-wire pixel receiver. Classifies each high pulse by width,
// captures the first 24 bits after a frame reset as one GRB pixel, then forwards
// the remainder of the frame on dout like a real daisy-chained pixel.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   din          - asynchronous serial pixel line
//   dout         - forwarded line (synchronized din while forwarding, else 0)
//   pixel_data   - last captured pixel, bit 23 first received
//   pixel_valid  - one-cycle pulse when pixel_data updates
//   frame_reset  - one-cycle pulse when a reset-length low period completes
//   bit_err      - one-cycle pulse on an illegal high-pulse width
module ws2812_decoder
    import ws2812_pkg::*;
#(
    parameter int unsigned T_MIN_CYC    = T_MIN_DEF,
    parameter int unsigned T_THRESH_CYC = T_THRESH_DEF,
    parameter int unsigned T_MAX_CYC    = T_MAX_DEF,
    parameter int unsigned RESET_CYC    = RESET_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    output logic               dout,
    output logic [PIXEL_W-1:0] pixel_data,
    output logic               pixel_valid,
    output logic               frame_reset,
    output logic               bit_err
);

    localparam int unsigned          CNT_W    = $clog2(RESET_CYC + 1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(PIXEL_W - 1);
    localparam logic [BIT_CNT_W-1:0] FULL_CNT = BIT_CNT_W'(PIXEL_W);

    state_t               state, state_d;
    logic                 din_s, din_q;
    logic                 rise, fall;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_CNT_W-1:0] bits, bits_d;
    logic [PIXEL_W-1:0]   shift, shift_d, shift_in;
    logic [PIXEL_W-1:0]   pixel_data_d;
    logic                 pixel_valid_d, frame_reset_d, bit_err_d, dout_d;
    logic [31:0]          hi_len;
    logic                 low_done, too_short, too_long, is_one;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (din_s)
    );

    // Edge detect on the synchronized line
    always_ff @(posedge clk) begin
        if (!rst_n) din_q <= 1'b0;
        else        din_q <= din_s;
    end

    assign rise = din_s & ~din_q;
    assign fall = ~din_s & din_q;

    // Shared high/low duration counter: cleared on each edge, saturating
    always_ff @(posedge clk) begin
        if (!rst_n)              cnt <= '0;
        else if (rise || fall)   cnt <= '0;
        else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
    end

    // cnt restarts one cycle after the edge, so at the fall it reads width-1,
    // and while still high the width seen so far is cnt+2.
    assign hi_len    = 32'(cnt) + 32'd1;
    assign too_short = hi_len < T_MIN_CYC;
    assign is_one    = hi_len >= T_THRESH_CYC;
    assign too_long  = din_s && ((hi_len + 32'd1) > T_MAX_CYC);
    assign low_done  = ~din_s && (cnt == CNT_W'(RESET_CYC));
    assign shift_in  = {shift[PIXEL_W-2:0], is_one};

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state;
        bits_d        = bits;
        shift_d       = shift;
        pixel_data_d  = pixel_data;
        pixel_valid_d = 1'b0;
        frame_reset_d = 1'b0;
        bit_err_d     = 1'b0;
        dout_d        = 1'b0;

        case (state)
            WAIT_RST: begin
                if (low_done) begin
                    frame_reset_d = 1'b1;
                    bits_d        = '0;
                    shift_d       = '0;
                    state_d       = IDLE;
                end
            end

            IDLE, LOW: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (low_done) begin
                    // Drop any partial pixel and restart the frame
                    frame_reset_d = 1'b1;
                    bits_d        = '0;
                    shift_d       = '0;
                    state_d       = IDLE;
                end
            end

            HIGH: begin
                if (fall) begin
                    if (too_short) begin
                        bit_err_d = 1'b1;
                        state_d   = ERR;
                    end else if (bits == LAST_BIT) begin
                        shift_d       = shift_in;
                        bits_d        = FULL_CNT;
                        pixel_data_d  = shift_in;
                        pixel_valid_d = 1'b1;
                        state_d       = FWD;
                    end else begin
                        shift_d = shift_in;
                        bits_d  = bits + BIT_CNT_W'(1);
                        state_d = LOW;
                    end
                end else if (too_long) begin
                    bit_err_d = 1'b1;
                    state_d   = ERR;
                end
            end

            FWD: begin
                // Pass-through only; widths are not checked while forwarding
                dout_d = din_s;
                if (low_done) begin
                    frame_reset_d = 1'b1;
                    bits_d        = '0;
                    shift_d       = '0;
                    dout_d        = 1'b0;
                    state_d       = IDLE;
                end
            end

            ERR: begin
                if (low_done) begin
                    frame_reset_d = 1'b1;
                    bits_d        = '0;
                    shift_d       = '0;
                    state_d       = IDLE;
                end
            end

            default: begin
                state_d = WAIT_RST;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= WAIT_RST;
            bits        <= '0;
            shift       <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            frame_reset <= 1'b0;
            bit_err     <= 1'b0;
            dout        <= 1'b0;
        end else begin
            state       <= state_d;
            bits        <= bits_d;
            shift       <= shift_d;
            pixel_data  <= pixel_data_d;
            pixel_valid <= pixel_valid_d;
            frame_reset <= frame_reset_d;
            bit_err     <= bit_err_d;
            dout        <= dout_d;
        end
    end

endmodule

// File: tb/tb_ws2812_decoder.sv
// Self-checking bench for ws2812_decoder: randomized pulse trains, a
// pulse-level reference model feeding an event scoreboard, and a per-cycle
// check of the forwarded line.
module tb_ws2812_decoder;

    localparam int T_MIN    = 5;
    localparam int T_THRESH = 25;
    localparam int T_MAX    = 50;
    localparam int RST_CYC  = 2500;
    localparam int HOLD     = RST_CYC + 20;

    typedef enum int {EV_PIX, EV_FR, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [23:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        dout;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        frame_reset;
    logic        bit_err;

    int errors = 0;
    int checks = 0;

    ev_t sb[$];

    // Reference model state (frame level)
    bit          m_synced = 1'b0;
    bit          m_err = 1'b0;
    bit          m_fwd = 1'b0;
    bit          m_quiet = 1'b0;
    int          m_nb = 0;
    logic [23:0] m_val = '0;
    bit          fwd_exp = 1'b0;

    bit p0 = 1'b0, p1 = 1'b0, p2 = 1'b0;

    ws2812_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .dout        (dout),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .frame_reset (frame_reset),
        .bit_err     (bit_err)
    );

    always #10 clk = ~clk;

    task automatic push_ev(input ev_kind_t k, input logic [23:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic check_eq(input string name, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_pixel_data"}, pixel_data, 24'h0);
        check_eq({tag, "_pixel_valid"}, 24'(pixel_valid), 24'h0);
        check_eq({tag, "_frame_reset"}, 24'(frame_reset), 24'h0);
        check_eq({tag, "_bit_err"}, 24'(bit_err), 24'h0);
        check_eq({tag, "_dout"}, 24'(dout), 24'h0);
    endtask

    // Scoreboard monitor: every output pulse must match the next expected event
    always @(negedge clk) begin
        if (pixel_valid || frame_reset || bit_err) begin
            ev_kind_t got;
            ev_t      e;
            int       n;
            n   = int'(pixel_valid) + int'(frame_reset) + int'(bit_err);
            got = pixel_valid ? EV_PIX : (frame_reset ? EV_FR : EV_ERR);
            checks++;
            if (n != 1) begin
                errors++;
                $display("FAIL pulse_overlap: %0d pulses in one cycle, expected 1 at %0t", n, $time);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %s, expected none at %0t", got.name(), $time);
            end else begin
                e = sb.pop_front();
                if (e.kind != got) begin
                    errors++;
                    $display("FAIL event_kind: got %s expected %s at %0t", got.name(), e.kind.name(), $time);
                end else if (got == EV_PIX) begin
                    checks++;
                    if (pixel_data !== e.data) begin
                        errors++;
                        $display("FAIL pixel_data: got %h expected %h at %0t", pixel_data, e.data, $time);
                    end
                end
            end
        end
    end

    // Forwarded line: din (only while forwarding is expected) delayed 3 cycles
    always @(posedge clk) begin
        p0 <= din & fwd_exp;
        p1 <= p0;
        p2 <= p1;
    end

    always @(negedge clk) begin
        checks++;
        if (dout !== p2) begin
            errors++;
            $display("FAIL dout: got %b expected %b at %0t", dout, p2, $time);
        end
    end

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            din = v;
            @(posedge clk);
            #1;
        end
    endtask

    // One high pulse followed by a short low gap
    task automatic send_pulse(input int h, input int l);
        bit b;
        if (m_synced && !m_err && !m_fwd) begin
            if (h < T_MIN || h > T_MAX) begin
                push_ev(EV_ERR, 24'h0);
                m_err = 1'b1;
            end else begin
                b     = (h >= T_THRESH);
                m_val = m_val * 24'd2 + 24'(b);
                m_nb++;
                if (m_nb == 24) begin
                    push_ev(EV_PIX, m_val);
                    m_fwd = 1'b1;
                end
            end
        end
        m_quiet = 1'b0;
        drive(1'b1, h);
        fwd_exp = m_fwd;
        drive(1'b0, l);
    endtask

    // Reset-length low period
    task automatic send_low(input int n);
        if (!m_quiet) push_ev(EV_FR, 24'h0);
        m_quiet  = 1'b1;
        m_synced = 1'b1;
        m_err    = 1'b0;
        m_fwd    = 1'b0;
        m_nb     = 0;
        m_val    = '0;
        fwd_exp  = 1'b0;
        drive(1'b0, n);
    endtask

    task automatic rand_bit_pulse(input bit b);
        int h;
        h = b ? int'($urandom_range(T_MAX, T_THRESH)) : int'($urandom_range(T_THRESH - 1, T_MIN));
        send_pulse(h, int'($urandom_range(60, 20)));
    endtask

    // mode 0: fixed nominal timing, 1: random legal, 2: boundary widths
    task automatic send_pixel(input logic [23:0] v, input int mode);
        for (int i = 23; i >= 0; i--) begin
            bit b;
            int h;
            int l;
            b = v[i];
            case (mode)
                0: begin
                    h = b ? 33 : 18;
                    l = b ? 28 : 43;
                    send_pulse(h, l);
                end
                1: rand_bit_pulse(b);
                default: begin
                    if (b) h = (i % 2 == 1) ? T_THRESH : T_MAX;
                    else    h = (i % 2 == 1) ? T_MIN : T_THRESH - 1;
                    send_pulse(h, 20);
                end
            endcase
        end
    endtask

    task automatic send_rand_bits(input int n);
        for (int i = 0; i < n; i++) rand_bit_pulse(1'($urandom_range(1, 0)));
    endtask

    task automatic apply_reset(input string tag);
        rst_n   = 1'b0;
        din     = 1'b0;
        fwd_exp = 1'b0;
        @(posedge clk);
        #1;
        check_zero(tag);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        m_synced = 1'b0;
        m_err    = 1'b0;
        m_fwd    = 1'b0;
        m_quiet  = 1'b0;
        m_nb     = 0;
        m_val    = '0;
        rst_n    = 1'b1;
    endtask

    initial begin
        logic [23:0] pv;

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check_zero("por");
        rst_n = 1'b1;

        // Nominal pixel, dout stays low for a lone pixel
        send_low(HOLD);
        send_pixel(24'hFF0055, 0);
        send_low(HOLD);

        // Back-to-back pixels: second one is forwarded
        send_pixel(24'h123456, 1);
        send_pixel(24'hABCDEF, 1);
        send_low(HOLD);

        // Too-long pulse mid-pixel, then recovery
        send_rand_bits(10);
        send_pulse(60, 40);
        send_rand_bits(3);
        send_low(HOLD);
        send_pixel(24'(($urandom)), 1);
        send_low(HOLD);

        // Partial pixel discarded by a frame reset
        send_rand_bits(12);
        send_low(HOLD);
        send_pixel(24'(($urandom)), 1);
        send_low(HOLD);

        // Short glitches and exact-boundary widths
        send_rand_bits(5);
        send_pulse(3, 30);
        send_rand_bits(2);
        send_low(HOLD);
        send_pulse(T_MIN - 1, 30);
        send_low(HOLD);
        send_pixel(24'hA5C3F0, 2);
        send_low(HOLD);

        // Random frames of one or two pixels
        for (int f = 0; f < 2; f++) begin
            int np;
            np = int'($urandom_range(2, 1));
            for (int p = 0; p < np; p++) send_pixel(24'(($urandom)), 1);
            send_low(HOLD);
        end

        // Pixel straight after reset is ignored; reset mid-pixel clears outputs
        apply_reset("rst_start");
        send_pixel(24'(($urandom)), 1);
        send_low(HOLD);
        pv = 24'(($urandom)) | 24'h800000;
        send_pixel(pv, 1);
        send_rand_bits(5);
        apply_reset("rst_mid");
        send_low(HOLD);
        send_pixel(24'(($urandom)), 1);
        send_low(HOLD);

        // Bounded drain of outstanding expectations
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d events outstanding, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ws2812_decoder.md
# ws2812_decoder

Receive-side counterpart of the single-wire pixel bit encoder. The block samples a WS2812-style data line and classifies each high pulse by its width as a 0 or 1 bit. It assembles the first 24 bits after a frame reset into one GRB pixel, then forwards the rest of the frame on `dout`, matching a real pixel in a daisy chain. It serves as a loopback checker for the encoder path and as an emulated pixel in chain tests.

## Interface
- `T_MIN_CYC`, default 5: minimum legal high width in clk cycles (100 ns at 50 MHz).
- `T_THRESH_CYC`, default 25: bit threshold. A high width below this is a 0; a width at or above it is a 1.
- `T_MAX_CYC`, default 50: maximum legal high width in clk cycles.
- `RESET_CYC`, default 2500: line-low time that signals a frame reset (50 µs at 50 MHz).
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, synchronous, active-low.
- `din` in 1: asynchronous serial pixel line.
- `dout` out 1: forwarded line; carries `din_s` only in FWD, otherwise 0.
- `pixel_data` out 24: last captured pixel. Bit 23 is the first bit received (G7).
- `pixel_valid` out 1: one-cycle pulse when `pixel_data` updates.
- `frame_reset` out 1: one-cycle pulse when a reset period completes.
- `bit_err` out 1: one-cycle pulse on an illegal pulse width.

## Operation
- `din` passes through a 2-FF synchronizer to produce `din_s`. An edge register `din_q` gives rise = `din_s & ~din_q` and fall = `~din_s & din_q`.
- One counter, width `$clog2(RESET_CYC+1)`, saturates at its maximum. It clears on every edge and increments every cycle otherwise.
- Bit counter is 5 bits (0–24). Shift register is 24 bits, shifted left with the new bit entering at bit 0.
- WAIT_RST: entered after `rst_n`. Edges are ignored here. When `din_s` has been low for a count of RESET_CYC, pulse `frame_reset` and go to IDLE.
- IDLE / LOW (between bits): on rise, go to HIGH. If low for a count of RESET_CYC, pulse `frame_reset`, clear the bit counter, discard any partial pixel and go to IDLE.
- HIGH: on fall, check the high count:
  - count < T_MIN_CYC: go to ERR.
  - count < T_THRESH_CYC: shift in 0.
  - otherwise: shift in 1.
  - If the count reaches T_MAX_CYC+1 while still high, go to ERR immediately.
- After the 24th bit shifts in: load `pixel_data`, pulse `pixel_valid`, go to FWD. Otherwise go to LOW.
- FWD: `dout = din_s`. A low period of RESET_CYC pulses `frame_reset` and returns to IDLE, with `dout` at 0. No width checks are made in FWD.
- ERR: `bit_err` pulses on entry. All edges are ignored. A low period of RESET_CYC pulses `frame_reset` and returns to IDLE.
- `rst_n` low overrides everything.
- `pixel_valid` and `frame_reset` can never occur in the same cycle.

## Timing
- Reset values: all outputs 0, state WAIT_RST, counters 0, shift register 0.
- `pixel_data`, `pixel_valid`, `bit_err` and `frame_reset` are registered outputs.
- `pixel_valid` is asserted 3 clk cycles after the first clk edge that samples the 24th bit's `din` falling edge low.
- A too-long pulse raises `bit_err` 3 cycles after the `din` high count exceeds T_MAX_CYC.
- `frame_reset` asserts the cycle after the low count equals RESET_CYC.
- `dout` lags `din` by 2 cycles, plus 1 for the output register, so 3 in total.
- A high count exactly equal to T_THRESH_CYC decodes as 1. A count exactly equal to T_MIN_CYC or T_MAX_CYC is legal.

## Structure
- Package `ws2812_pkg` holds:
  - the state enum (WAIT_RST, IDLE, HIGH, LOW, FWD, ERR),
  - `PIXEL_W = 24`,
  - default timing constants for 50 MHz.
- Sub-module `sync_2ff` provides the input synchronizer. The rest is one FSM module.

## Test plan
- Reset, hold `din` low for 2500 cycles, then send 24'hFF0055 with 0 = 18 high / 43 low and 1 = 33 high / 28 low, then hold low for 2500 cycles. Required: one `pixel_valid` with `pixel_data` = 24'hFF0055, one `frame_reset`, and `dout` held at 0 throughout.
- Send 24'h123456 then 24'hABCDEF back to back. Required: `pixel_data` = 24'h123456, and `dout` reproduces the second pixel's waveform delayed by 3 cycles.
- Send a 60-cycle high pulse mid-pixel. Required: `bit_err` pulses, no `pixel_valid`. After 2500 low cycles, `frame_reset` pulses and the next pixel decodes correctly.
- Send 12 bits, then hold low for 2500 cycles. Required: `frame_reset` pulses, no `pixel_valid`, and the next 24 bits decode from an empty shift register.
- Send a 3-cycle glitch high. Required: `bit_err` pulses. Send high widths of exactly 25 and 50 cycles. Required: both decode as 1 with no error.
- Release `rst_n` and send a pixel immediately, without a preceding low period. Required: no `pixel_valid`. Assert `rst_n` low mid-pixel. Required: all outputs read 0 on the next clk edge.
